sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-ported synchronous SRAM between the core's instruction-fetch and data-access requesters.
//  Arbitrates per cycle with data priority and an instruction anti-starvation guard.
//  Tracks the single in-flight access so each read/write response returns to the requester that issued it.
//  Sits between mycpu_top's inst/data sram ports and a unified memory.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width (byte-write enables = DATA_W/8)
//  STARVE_MAX  4   consecutive data grants tolerated while inst waits, then inst wins (>=1)
// PORTS
//  clk           in   1         clock, rising edge
//  resetn        in   1         asynchronous active-low reset
//  inst_req      in   1         fetch request valid (read only)
//  inst_addr     in   ADDR_W    fetch address
//  inst_addr_ok  out  1         fetch request accepted this cycle
//  inst_data_ok  out  1         fetch data valid this cycle
//  inst_rdata    out  DATA_W    fetch data
//  data_req      in   1         load/store request valid
//  data_we       in   DATA_W/8  byte write enables; 0 = read
//  data_addr     in   ADDR_W    load/store address
//  data_wdata    in   DATA_W    store data
//  data_addr_ok  out  1         load/store accepted this cycle
//  data_data_ok  out  1         load data valid / store done this cycle
//  data_rdata    out  DATA_W    load data
//  sram_en       out  1         SRAM access enable
//  sram_we       out  DATA_W/8  SRAM byte write enables
//  sram_addr     out  ADDR_W    SRAM address
//  sram_wdata    out  DATA_W    SRAM write data
//  sram_rdata    in   DATA_W    SRAM read data, valid 1 cycle after sram_en
// BEHAVIOUR
//  - Grant is combinational each cycle: data_req only -> data; inst_req only -> inst; both -> data,
//    unless streak==STARVE_MAX, then inst. Neither -> no grant, sram_en=0, sram_we=0.
//  - Granted requester sees addr_ok=1 in the same cycle; the other sees addr_ok=0 and must hold its request.
//  - sram_en/we/addr/wdata mux from the granted requester; inst grant forces sram_we=0, sram_wdata=0.
//  - Registered response tracker: resp_valid<=grant!=none, resp_owner<=granted id. Next cycle:
//    owner's data_ok=1; its rdata=sram_rdata (stores return data_ok with rdata don't-care).
//  - Latency is exactly 1 cycle, addr_ok to data_ok. Fully pipelined: a new grant can occur in the
//    same cycle a response returns; back-to-back grants give back-to-back data_ok.
//  - Non-owner rdata is driven 0; data_ok never asserts for both requesters in one cycle.
//  - Streak counter (width clog2(STARVE_MAX+1)): +1 when data granted while inst_req=1; cleared
//    when inst granted or inst_req=0; saturates at STARVE_MAX; must never wrap.
//  - Request inputs are level-held by requesters; the arbiter stores no request state beyond the tracker.
//  - Reset (resetn=0, async): resp_valid=0, resp_owner=inst, streak=0. While in reset, all addr_ok,
//    data_ok, sram_en and sram_we are 0 and rdata outputs are 0. Reset mid-access drops the in-flight
//    response; no data_ok follows reset release.
//  - Reset outputs: every output is 0.
//  - Response is not back-pressured; requesters must accept data_ok in its cycle.
// TESTING
//  1. Inst only, inst_addr=0x1C000000, 3 cycles -> addr_ok each cycle; inst_data_ok cycles 2-4;
//     rdata=mem; sram_we=0.
//  2. Data store we=4'hF addr=0x100 wdata=0xDEADBEEF, then load 0x100 -> data_data_ok on consecutive
//     cycles; load rdata=0xDEADBEEF.
//  3. Both requesting continuously, STARVE_MAX=4 -> grant pattern D,D,D,D,I repeating; no data_ok overlap.
//  4. Data grant, then inst grant next cycle -> data_data_ok, then inst_data_ok, each with its own
//     rdata; non-owner rdata=0.
//  5. resetn low in the cycle after a load grant -> no data_data_ok ever; all outputs 0 during reset;
//     streak=0 after release.
//  6. inst_req drops for 1 cycle mid-streak (streak=3) -> streak clears; inst then waits 4 data grants.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester-side SRAM-like channel: request/address handshake plus a
// one-cycle-later data response. Used for both the fetch and the load/store port.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic [DATA_W/8-1:0]   we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    // The requester drives the request side and receives the handshakes
    modport master (
        output req, we, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    // The arbiter receives the request side and drives the handshakes
    modport slave (
        input  req, we, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between instruction fetch and data
// access. Data wins by default; after STARVE_MAX consecutive data grants with
// fetch waiting, fetch wins once. One in-flight access is tracked so the
// response (exactly one cycle after the grant) returns to its issuer.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_port_arbiter_if.slave   inst_bus,
    sram_port_arbiter_if.slave   data_bus,
    output logic                 sram_en,
    output logic [DATA_W/8-1:0]  sram_we,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata
);

    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_INST = 2'd1,
        GRANT_DATA = 2'd2
    } grant_e;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    grant_e                grant;
    owner_e                resp_owner;
    logic                  resp_valid;
    logic [STREAK_W-1:0]   streak;
    logic [STREAK_W-1:0]   streak_next;

    // The fetch port is read-only, so its write fields are intentionally ignored
    logic unused_inst_write;
    assign unused_inst_write = ^{inst_bus.we, inst_bus.wdata};

    // Per-cycle grant; nothing is granted while reset is held so every output stays 0
    always_comb begin
        grant = GRANT_NONE;
        if (resetn) begin
            if (data_bus.req && inst_bus.req) begin
                grant = (streak == STREAK_LIMIT) ? GRANT_INST : GRANT_DATA;
            end else if (data_bus.req) begin
                grant = GRANT_DATA;
            end else if (inst_bus.req) begin
                grant = GRANT_INST;
            end
        end
    end

    // Steer the granted requester onto the SRAM and acknowledge it in the same cycle
    always_comb begin
        sram_en          = 1'b0;
        sram_we          = '0;
        sram_addr        = '0;
        sram_wdata       = '0;
        inst_bus.addr_ok = 1'b0;
        data_bus.addr_ok = 1'b0;
        case (grant)
            GRANT_INST: begin
                sram_en          = 1'b1;
                sram_addr        = inst_bus.addr;
                inst_bus.addr_ok = 1'b1;
            end
            GRANT_DATA: begin
                sram_en          = 1'b1;
                sram_we          = data_bus.we;
                sram_addr        = data_bus.addr;
                sram_wdata       = data_bus.wdata;
                data_bus.addr_ok = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Count data grants that made a waiting fetch lose; saturate instead of wrapping
    always_comb begin
        streak_next = streak;
        if (grant == GRANT_INST || !inst_bus.req) begin
            streak_next = '0;
        end else if (grant == GRANT_DATA && streak != STREAK_LIMIT) begin
            streak_next = streak + 1'b1;
        end
    end

    // Remember who owns the access in flight, and the starvation streak
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_owner <= OWNER_INST;
            streak     <= '0;
        end else begin
            resp_valid <= (grant != GRANT_NONE);
            resp_owner <= (grant == GRANT_DATA) ? OWNER_DATA : OWNER_INST;
            streak     <= streak_next;
        end
    end

    // Route the SRAM read data only to the owner of the returning access
    always_comb begin
        inst_bus.data_ok = resp_valid && (resp_owner == OWNER_INST);
        data_bus.data_ok = resp_valid && (resp_owner == OWNER_DATA);
        inst_bus.rdata   = inst_bus.data_ok ? sram_rdata : '0;
        data_bus.rdata   = data_bus.data_ok ? sram_rdata : '0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: a behavioural SRAM, a reference
// arbitration/memory model feeding an expected-response queue, and a monitor
// that pops and compares whenever a data_ok appears.
module tb_sram_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic        is_inst;
        logic        is_store;
        logic [31:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    int    err_cnt = 0;
    int    chk_cnt = 0;
    int    passed_over = 0;
    string grant_log = "";
    resp_t exp_q[$];

    logic [31:0] sram_mem [logic [29:0]];
    logic [31:0] ref_mem  [logic [29:0]];

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) inst_bus ();
    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) data_bus ();

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_bus(inst_bus), .data_bus(data_bus),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Power-on contents of any word never written
    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w[13:0], 2'b01, w[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        logic [31:0] w;
        w = ref_read(a);
        for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        ref_mem[a[31:2]] = w;
    endfunction

    // Behavioural synchronous SRAM: read data one cycle after the enable
    always @(posedge clk) begin : sram_model
        logic [31:0] word;
        if (sram_en) begin
            word = sram_mem.exists(sram_addr[31:2]) ? sram_mem[sram_addr[31:2]] : init_word(sram_addr[31:2]);
            sram_rdata <= word;
            for (int b = 0; b < 4; b++) if (sram_we[b]) word[b*8 +: 8] = sram_wdata[b*8 +: 8];
            sram_mem[sram_addr[31:2]] = word;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference arbitration: data wins unless fetch has already lost STARVE_MAX times in a row
    function automatic int predict_grant(input logic i_req, input logic d_req);
        if (i_req && d_req) return (passed_over >= STARVE_MAX) ? 1 : 2;
        if (d_req) return 2;
        if (i_req) return 1;
        return 0;
    endfunction

    // Drive one cycle of requests, check the same-cycle grant, queue the expected response
    task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                                 input logic d_req, input logic [3:0] d_we,
                                 input logic [31:0] d_addr, input logic [31:0] d_wdata,
                                 output int granted);
        resp_t e;
        @(negedge clk);
        inst_bus.req = i_req;  inst_bus.addr = i_addr;  inst_bus.we = '0;  inst_bus.wdata = '0;
        data_bus.req = d_req;  data_bus.addr = d_addr;  data_bus.we = d_we; data_bus.wdata = d_wdata;
        #1;
        granted = predict_grant(i_req, d_req);
        grant_log = {grant_log, data_bus.addr_ok ? "D" : (inst_bus.addr_ok ? "I" : "-")};
        checkOutput("inst_addr_ok", inst_bus.addr_ok, granted == 1);
        checkOutput("data_addr_ok", data_bus.addr_ok, granted == 2);
        checkOutput("sram_en", sram_en, granted != 0);
        checkOutput("sram_we", sram_we, (granted == 2) ? d_we : 4'h0);
        checkOutput("sram_addr", sram_addr, (granted == 2) ? d_addr : ((granted == 1) ? i_addr : 32'h0));
        checkOutput("sram_wdata", sram_wdata, (granted == 2) ? d_wdata : 32'h0);
        if (granted == 1) begin
            e.is_inst = 1'b1; e.is_store = 1'b0; e.rdata = ref_read(i_addr);
            exp_q.push_back(e);
            passed_over = 0;
        end else if (granted == 2) begin
            e.is_inst = 1'b0; e.is_store = (d_we != 4'h0); e.rdata = ref_read(d_addr);
            if (d_we != 4'h0) ref_write(d_addr, d_we, d_wdata);
            exp_q.push_back(e);
            passed_over = i_req ? passed_over + 1 : 0;
        end else begin
            passed_over = 0;
        end
    endtask

    task automatic check_reset_outputs();
        checkOutput("rst_inst_addr_ok", inst_bus.addr_ok, 0);
        checkOutput("rst_data_addr_ok", data_bus.addr_ok, 0);
        checkOutput("rst_inst_data_ok", inst_bus.data_ok, 0);
        checkOutput("rst_data_data_ok", data_bus.data_ok, 0);
        checkOutput("rst_inst_rdata", inst_bus.rdata, 0);
        checkOutput("rst_data_rdata", data_bus.rdata, 0);
        checkOutput("rst_sram_en", sram_en, 0);
        checkOutput("rst_sram_we", sram_we, 0);
        checkOutput("rst_sram_addr", sram_addr, 0);
        checkOutput("rst_sram_wdata", sram_wdata, 0);
    endtask

    // Monitor: every data_ok pops one expected response; a silent cycle with a pending one is a miss
    initial begin : monitor
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (inst_bus.data_ok || data_bus.data_ok) begin
                checkOutput("data_ok_overlap", inst_bus.data_ok && data_bus.data_ok, 0);
                if (exp_q.size() == 0) begin
                    checkOutput("pending_responses", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_owner", {inst_bus.data_ok, data_bus.data_ok}, e.is_inst ? 2'b10 : 2'b01);
                    if (e.is_inst) begin
                        checkOutput("inst_rdata", inst_bus.rdata, e.rdata);
                        checkOutput("data_rdata_nonowner", data_bus.rdata, 0);
                    end else begin
                        checkOutput("inst_rdata_nonowner", inst_bus.rdata, 0);
                        if (!e.is_store) checkOutput("data_rdata", data_bus.rdata, e.rdata);
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("missing_data_ok", {inst_bus.data_ok, data_bus.data_ok}, e.is_inst ? 2'b10 : 2'b01);
            end
        end
    end

    // Safety net so the run always ends
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized level-held traffic
    initial begin : driver
        int          g;
        logic        i_pend, d_pend;
        logic [31:0] i_addr, d_addr, d_wdata;
        logic [3:0]  d_we;
        int          r;

        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000; inst_bus.we = '0; inst_bus.wdata = '0;
        data_bus.req = 1'b1; data_bus.addr = 32'h100; data_bus.we = 4'hF; data_bus.wdata = 32'h1234;
        #6;
        check_reset_outputs();
        inst_bus.req = 1'b0; data_bus.req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        $display("[TB] fetch-only stream");
        repeat (3) applyStimulus(1, 32'h1C00_0000, 0, 4'h0, 32'h0, 32'h0, g);

        $display("[TB] store then load");
        applyStimulus(0, 32'h0, 1, 4'hF, 32'h100, 32'hDEADBEEF, g);
        applyStimulus(0, 32'h0, 1, 4'h0, 32'h100, 32'h0, g);
        checkOutput("ref_store_value", ref_read(32'h100), 32'hDEADBEEF);

        $display("[TB] continuous contention");
        grant_log = "";
        repeat (10) applyStimulus(1, 32'h1C00_0010, 1, 4'h0, 32'h104, 32'h0, g);
        chk_cnt++;
        if (grant_log != "DDDDIDDDDI") begin
            err_cnt++;
            $display("[TB] FAIL grant_pattern: got %s, expected DDDDIDDDDI", grant_log);
        end

        $display("[TB] data then fetch");
        applyStimulus(0, 32'h0, 1, 4'h0, 32'h100, 32'h0, g);
        applyStimulus(1, 32'h1C00_0004, 0, 4'h0, 32'h0, 32'h0, g);

        $display("[TB] fetch drops mid-streak");
        grant_log = "";
        repeat (3) applyStimulus(1, 32'h1C00_0008, 1, 4'h0, 32'h108, 32'h0, g);
        applyStimulus(0, 32'h0, 1, 4'h0, 32'h108, 32'h0, g);
        repeat (5) applyStimulus(1, 32'h1C00_0008, 1, 4'h0, 32'h108, 32'h0, g);
        chk_cnt++;
        if (grant_log != "DDDDDDDDI") begin
            err_cnt++;
            $display("[TB] FAIL streak_clear_pattern: got %s, expected DDDDDDDDI", grant_log);
        end

        $display("[TB] reset during an access");
        applyStimulus(0, 32'h0, 1, 4'h0, 32'h100, 32'h0, g);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        passed_over = 0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0020;
        #1;
        check_reset_outputs();
        repeat (2) begin
            @(negedge clk);
            #1;
            check_reset_outputs();
        end
        inst_bus.req = 1'b0; data_bus.req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        grant_log = "";
        repeat (5) applyStimulus(1, 32'h1C00_0020, 1, 4'h0, 32'h10C, 32'h0, g);
        chk_cnt++;
        if (grant_log != "DDDDI") begin
            err_cnt++;
            $display("[TB] FAIL post_reset_pattern: got %s, expected DDDDI", grant_log);
        end

        $display("[TB] randomized traffic");
        i_pend = 1'b0; d_pend = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_we = '0;
        for (int c = 0; c < 400; c++) begin
            if (!i_pend) begin
                i_pend = ($urandom_range(0, 99) < 60);
                i_addr = 32'h1C00_0000 + 32'($urandom_range(0, 15) * 4);
            end
            if (!d_pend) begin
                d_pend  = ($urandom_range(0, 99) < 55);
                d_addr  = 32'h100 + 32'($urandom_range(0, 15) * 4);
                d_wdata = $urandom;
                r = $urandom_range(0, 3);
                d_we = (r < 2) ? 4'h0 : ((r == 2) ? 4'hF : 4'($urandom_range(1, 15)));
            end
            applyStimulus(i_pend, i_addr, d_pend, d_we, d_addr, d_wdata, g);
            if (g == 1) i_pend = 1'b0;
            if (g == 2) d_pend = 1'b0;
        end

        repeat (2) applyStimulus(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, g);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
